// File: rtl/sram_port_arbiter.sv
// Arbitrates the fetch and MEM-stage requesters onto one SRAM-like port.
// One transaction in flight; data requests win over fetches.
module sram_port_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_inst_req,
    input  logic [31:0] i_inst_addr,
    output logic        o_inst_gnt,
    output logic        o_inst_rvalid,
    output logic [31:0] o_inst_rdata,
    input  logic        i_data_req,
    input  logic [3:0]  i_data_we,
    input  logic [31:0] i_data_addr,
    input  logic [31:0] i_data_wdata,
    output logic        o_data_gnt,
    output logic        o_data_rvalid,
    output logic [31:0] o_data_rdata,
    output logic        o_mem_req,
    output logic [3:0]  o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_addr_ok,
    input  logic        i_mem_data_ok,
    input  logic [31:0] i_mem_rdata,
    output logic        o_stall_req,
    output logic        o_timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_owner_data;
    logic [3:0]  r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [7:0]  r_cnt;

    logic w_idle;
    logic w_gnt_data;
    logic w_gnt_inst;
    logic w_done;
    logic w_expire;

    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    assign w_idle     = (r_state == S_IDLE);
    assign w_gnt_data = w_idle & i_data_req;
    assign w_gnt_inst = w_idle & i_inst_req & ~i_data_req;
    assign w_done     = (r_state == S_WAIT) & i_mem_data_ok;
    // Last allowed WAIT cycle without data_ok aborts the transaction.
    assign w_expire   = (r_state == S_WAIT) & ~i_mem_data_ok & (r_cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (i_data_req | i_inst_req) w_next = S_ADDR;
            S_ADDR: if (i_mem_addr_ok) w_next = S_WAIT;
            S_WAIT: if (w_done | w_expire) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner_data <= 1'b0;
            r_we         <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_cnt        <= '0;
        end else begin
            if (w_gnt_data) begin
                r_owner_data <= 1'b1;
                r_we         <= i_data_we;
                r_addr       <= i_data_addr;
                r_wdata      <= i_data_wdata;
            end else if (w_gnt_inst) begin
                r_owner_data <= 1'b0;
                r_we         <= '0;
                r_addr       <= i_inst_addr;
            end
            if ((r_state == S_ADDR) && i_mem_addr_ok) begin
                r_cnt <= '0;
            end else if ((r_state == S_WAIT) && (r_cnt != 8'hFF)) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    // Control outputs are forced low while reset is held.
    always_comb begin
        o_inst_gnt    = 1'b0;
        o_data_gnt    = 1'b0;
        o_inst_rvalid = 1'b0;
        o_data_rvalid = 1'b0;
        o_mem_req     = 1'b0;
        o_stall_req   = 1'b0;
        o_timeout_err = 1'b0;
        if (!rst) begin
            o_inst_gnt    = w_gnt_inst;
            o_data_gnt    = w_gnt_data;
            o_inst_rvalid = w_done & ~r_owner_data;
            o_data_rvalid = w_done & r_owner_data;
            o_mem_req     = (r_state == S_ADDR);
            o_stall_req   = ~w_idle | (i_inst_req & i_data_req);
            o_timeout_err = w_expire;
        end
    end

    assign o_mem_we     = r_we;
    assign o_mem_addr   = r_addr;
    assign o_mem_wdata  = r_wdata;
    assign o_inst_rdata = i_mem_rdata;
    assign o_data_rdata = i_mem_rdata;

endmodule
